// File: rtl/mpmc11_rd_data_gather.sv
// ---------------------------------------------------------------------------
// mpmc11_rd_data_gather : buffers DRAM read beats and returns them, address-tagged, to a channel
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mpmc11_rd_data_gather #(
  parameter int WID   = 256,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [7:0]     burst_len,
  input  logic [31:0]    addr_base,
  input  logic           rd_data_valid,
  input  logic [WID-1:0] rd_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WID-1:0] out_data,
  output logic [31:0]    out_addr,
  output logic           out_last,
  output logic           busy,
  output logic           done,
  output logic           err_overflow,
  output logic           err_unexp
);

  localparam int c_AW      = $clog2(DEPTH);
  localparam int c_INC_AMT = WID / 8;

  localparam logic [1:0] c_S_IDLE    = 2'd0;
  localparam logic [1:0] c_S_COLLECT = 2'd1;
  localparam logic [1:0] c_S_DRAIN   = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;

  logic [7:0]      r_len;
  logic [31:0]     r_addr;
  logic [8:0]      r_rcv_cnt;
  logic [8:0]      r_out_cnt;

  logic [WID-1:0]  r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;

  logic            r_done;
  logic            r_err_ovf;
  logic            r_err_unexp;

  logic            w_start;
  logic            w_push;
  logic            w_push_ok;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_unexp;
  logic            w_rcv_done;
  logic            w_last;
  logic [29:0]     w_addr_sum;

  assign w_start    = start & (r_state == c_S_IDLE);
  assign w_full     = (r_count == (c_AW+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = rd_data_valid & (r_state == c_S_COLLECT);
  assign w_unexp    = rd_data_valid & (r_state != c_S_COLLECT);
  assign w_pop      = ~w_empty & out_ready;
  assign w_push_ok  = w_push & (~w_full | w_pop);
  assign w_rcv_done = w_push & (r_rcv_cnt == {1'b0, r_len});

  // Once draining, the sole remaining entry is the final beat even if an
  // earlier overflow dropped one and out_cnt can no longer reach len.
  assign w_last = ~w_empty &
                  ((r_out_cnt == {1'b0, r_len}) |
                   ((r_state == c_S_DRAIN) & (r_count == (c_AW+1)'(1))));

  assign w_addr_sum = r_addr[29:0] + (30'(r_out_cnt) * 30'(c_INC_AMT));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE:    if (w_start)          w_next_state = c_S_COLLECT;
      c_S_COLLECT: if (w_rcv_done)       w_next_state = c_S_DRAIN;
      c_S_DRAIN:   if (w_pop & w_last)   w_next_state = c_S_IDLE;
      default:                           w_next_state = c_S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy         = (r_state != c_S_IDLE);
    out_valid    = ~w_empty;
    out_last     = w_last;
    out_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    out_addr     = w_empty ? '0 : {2'b00, w_addr_sum};
    done         = r_done;
    err_overflow = r_err_ovf;
    err_unexp    = r_err_unexp;
  end

  // Burst bookkeeping and sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= '0;
      r_addr      <= '0;
      r_rcv_cnt   <= '0;
      r_out_cnt   <= '0;
      r_done      <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_unexp <= 1'b0;
    end else begin
      r_done <= w_pop & w_last;
      if (w_start) begin
        r_len       <= burst_len;
        r_addr      <= {addr_base[31:5], 5'h0};
        r_rcv_cnt   <= '0;
        r_out_cnt   <= '0;
        r_err_ovf   <= 1'b0;
        r_err_unexp <= 1'b0;
      end else begin
        if (w_push) r_rcv_cnt <= r_rcv_cnt + 9'd1;
        if (w_pop)  r_out_cnt <= r_out_cnt + 9'd1;
      end
      if (w_push & w_full & ~w_pop) r_err_ovf   <= 1'b1;
      if (w_unexp)                  r_err_unexp <= 1'b1;
    end
  end

  // FIFO pointers; a new burst always starts from an empty buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= rd_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_mpmc11_rd_data_gather.sv
// ---------------------------------------------------------------------------
// tb_mpmc11_rd_data_gather : table-driven bursts with a scoreboard of expected beats
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mpmc11_rd_data_gather;

  localparam int WID = 256;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [7:0]     burst_len = '0;
  logic [31:0]    addr_base = '0;
  logic           rd_data_valid = 1'b0;
  logic [WID-1:0] rd_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [WID-1:0] out_data;
  logic [31:0]    out_addr;
  logic           out_last;
  logic           busy;
  logic           done;
  logic           err_overflow;
  logic           err_unexp;

  mpmc11_rd_data_gather #(.WID(WID), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .addr_base(addr_base),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .done(done), .err_overflow(err_overflow), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  len;
    logic [31:0] base;
    int          stall;     // out_ready held low while beats 0..stall-1 are driven
    int          drop;      // index of the beat expected to be lost to overflow, -1 none
    logic        exp_ovf;
    logic [31:0] exp_first;
  } vec_t;

  typedef struct {
    logic [WID-1:0] d;
    logic [31:0]    a;
    logic           l;
  } sb_t;

  vec_t   vecs[7];
  sb_t    sb[$];
  int     n_vec = 0;
  int     n_miss = 0;
  logic   exp_done = 1'b0;
  logic   seen_done = 1'b0;
  logic   first_pending = 1'b0;
  logic   [31:0] got_first = '0;
  logic   held = 1'b0;
  logic   [WID-1:0] prev_d;
  logic   [31:0] prev_a;
  logic   prev_l;

  task automatic check(input string nm, input logic [WID-1:0] got, input logic [WID-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int k);
    logic [31:0] a;
    a = {base[31:5], 5'h0} + 32'(k) * 32'd32;
    a[31:30] = 2'b00;
    return a;
  endfunction

  function automatic logic [WID-1:0] rnd_beat();
    logic [WID-1:0] r;
    for (int j = 0; j < WID/32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  // Output monitor: scoreboard pop, done pulse and stall-stability checks
  always @(negedge clk) begin
    if (rst) begin
      held     = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_done) begin
        check("done_pulse", WID'(done), WID'(1'b1));
        exp_done  = 1'b0;
        seen_done = 1'b1;
      end else if (done) begin
        check("done_spurious", WID'(done), WID'(1'b0));
      end
      if (out_valid && !out_ready) begin
        if (held) begin
          check("hold_data", out_data, prev_d);
          check("hold_addr", WID'(out_addr), WID'(prev_a));
          check("hold_last", WID'(out_last), WID'(prev_l));
        end
        held = 1'b1;
        prev_d = out_data; prev_a = out_addr; prev_l = out_last;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("pop_unexpected", WID'(out_valid), WID'(1'b0));
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("beat_data", out_data, e.d);
          check("beat_addr", WID'(out_addr), WID'(e.a));
          check("beat_last", WID'(out_last), WID'(e.l));
        end
        if (first_pending) begin
          got_first     = out_addr;
          first_pending = 1'b0;
        end
        if (out_last) exp_done = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy && sb.size() == 0) break;
    end
    if (i == 300) check("idle_timeout", WID'(busy), WID'(1'b0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int k = 0;
    first_pending = 1'b1;
    seen_done     = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; burst_len = v.len; addr_base = v.base; out_ready = (v.stall == 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      if (i == v.stall) out_ready = 1'b1;
      rd_data_valid = 1'b1;
      rd_data = rnd_beat();
      if (i != v.drop) begin
        sb.push_back('{rd_data, exp_addr(v.base, k), (i == int'(v.len))});
        k++;
      end
      @(posedge clk); #1;
    end
    rd_data_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("err_overflow", WID'(err_overflow), WID'(v.exp_ovf));
    check("err_unexp_clr", WID'(err_unexp), WID'(1'b0));
    check("busy_end", WID'(busy), WID'(1'b0));
    check("valid_end", WID'(out_valid), WID'(1'b0));
    check("done_seen", WID'(seen_done), WID'(1'b1));
    check("first_addr", WID'(got_first), WID'(v.exp_first));
  endtask

  initial begin
    vecs[0] = '{8'd3,  32'h1000_0013, 0,  -1, 1'b0, 32'h1000_0000};
    vecs[1] = '{8'd0,  32'h2000_0100, 0,  -1, 1'b0, 32'h2000_0100};
    vecs[2] = '{8'd19, 32'h0000_4000, 17, 16, 1'b1, 32'h0000_4000};
    vecs[3] = '{8'd16, 32'h0000_8000, 16, -1, 1'b0, 32'h0000_8000};
    vecs[4] = '{8'd1,  32'h3FFF_FFE0, 0,  -1, 1'b0, 32'h3FFF_FFE0};
    vecs[5] = '{8'd2,  32'hC000_0040, 0,  -1, 1'b0, 32'h0000_0040};
    vecs[6] = '{8'd5,  32'h0123_4567, 3,  -1, 1'b0, 32'h0123_4560};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", WID'(out_valid), WID'(1'b0));
    check("rst_busy", WID'(busy), WID'(1'b0));
    check("rst_done", WID'(done), WID'(1'b0));
    check("rst_errs", WID'({err_overflow, err_unexp}), WID'(2'b00));
    check("rst_data", out_data, '0);
    rst = 1'b0;

    for (int n = 0; n < 7; n++) run_vec(vecs[n]);

    // Beat arriving while idle is discarded and flagged
    @(posedge clk); #1;
    rd_data_valid = 1'b1; rd_data = rnd_beat();
    @(posedge clk); #1;
    rd_data_valid = 1'b0;
    check("unexp_flag", WID'(err_unexp), WID'(1'b1));
    check("unexp_valid", WID'(out_valid), WID'(1'b0));
    check("unexp_busy", WID'(busy), WID'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    check("unexp_valid_later", WID'(out_valid), WID'(1'b0));
    run_vec(vecs[0]);   // the next start must clear err_unexp

    // Reset mid-burst after 2 of 4 beats
    @(posedge clk); #1;
    start = 1'b1; burst_len = 8'd3; addr_base = 32'h0000_2000; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_data_valid = 1'b1; rd_data = rnd_beat();
      @(posedge clk); #1;
    end
    check("mid_valid_before", WID'(out_valid), WID'(1'b1));
    rst = 1'b1; rd_data_valid = 1'b0;
    #1;
    check("mid_rst_valid", WID'(out_valid), WID'(1'b0));
    check("mid_rst_busy", WID'(busy), WID'(1'b0));
    check("mid_rst_data", out_data, '0);
    check("mid_rst_addr", WID'(out_addr), '0);
    check("mid_rst_last_done", WID'({out_last, done}), WID'(2'b00));
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_valid", WID'(out_valid), WID'(1'b0));
    check("post_rst_busy", WID'(busy), WID'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
